// File: rtl/drive_arbiter.sv
// Wheel command bus owner: arbitrates collision stop > junction maneuver > line follower,
// clamps duty, and forces a dead-time with drive disabled before any direction flip.
module drive_arbiter #(
    parameter int DEADTIME_CYCLES = 50_000,
    parameter int MAX_DUTY        = 80,
    parameter int CNT_W           = 27
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             col_stop,
    input  logic             lf_valid,
    input  logic [1:0]       lf_dir,
    input  logic [6:0]       lf_duty_l,
    input  logic [6:0]       lf_duty_r,
    input  logic             jn_req,
    input  logic [1:0]       jn_dir,
    input  logic [6:0]       jn_duty_l,
    input  logic [6:0]       jn_duty_r,
    input  logic [CNT_W-1:0] jn_cycles,
    output logic             jn_gnt,
    output logic             jn_done,
    output logic             jn_abort,
    output logic             mot_en,
    output logic [1:0]       mot_dir,
    output logic [6:0]       mot_duty_l,
    output logic [6:0]       mot_duty_r,
    output logic [1:0]       owner
);

    typedef enum logic [2:0] {S_IDLE, S_FOLLOW, S_MANEUVER, S_DEAD, S_COLLIDE} state_t;

    localparam logic [CNT_W-1:0] DT_LOAD = (DEADTIME_CYCLES < 1) ? CNT_W'(1) : CNT_W'(DEADTIME_CYCLES);
    localparam logic [6:0]       DUTY_MAX = 7'(MAX_DUTY);

    function automatic logic [6:0] clamp(input logic [6:0] d);
        return (d > DUTY_MAX) ? DUTY_MAX : d;
    endfunction

    function automatic logic [CNT_W-1:0] len_of(input logic [CNT_W-1:0] c);
        return (c == '0) ? CNT_W'(1) : c;
    endfunction

    state_t           state, state_nx;
    logic             pend_jn, pend_jn_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [1:0]       jl_dir, jl_dir_nx;
    logic [6:0]       jl_duty_l, jl_duty_l_nx, jl_duty_r, jl_duty_r_nx;
    logic [CNT_W-1:0] jl_cycles, jl_cycles_nx;
    logic             en_nx, gnt_nx, done_nx, abort_nx;
    logic [1:0]       dir_nx, owner_nx;
    logic [6:0]       dl_nx, dr_nx;
    logic [CNT_W-1:0] jn_len, jl_len;

    assign jn_len = len_of(jn_cycles);
    assign jl_len = len_of(jl_cycles);

    always_comb begin
        state_nx     = state;
        pend_jn_nx   = pend_jn;
        cnt_nx       = cnt;
        jl_dir_nx    = jl_dir;
        jl_duty_l_nx = jl_duty_l;
        jl_duty_r_nx = jl_duty_r;
        jl_cycles_nx = jl_cycles;
        en_nx        = 1'b0;
        dir_nx       = mot_dir;
        dl_nx        = 7'd0;
        dr_nx        = 7'd0;
        owner_nx     = 2'd0;
        gnt_nx       = 1'b0;
        done_nx      = 1'b0;
        abort_nx     = 1'b0;
        if (col_stop) begin
            state_nx = S_COLLIDE;
            owner_nx = 2'd3;
            abort_nx = (state == S_MANEUVER) || ((state == S_DEAD) && pend_jn);
        end else begin
            unique case (state)
                S_IDLE, S_FOLLOW: begin
                    state_nx = S_IDLE;
                    if (jn_req) begin
                        jl_dir_nx    = jn_dir;
                        jl_duty_l_nx = jn_duty_l;
                        jl_duty_r_nx = jn_duty_r;
                        jl_cycles_nx = jn_cycles;
                        owner_nx     = 2'd2;
                        if (jn_dir == mot_dir) begin
                            state_nx = S_MANEUVER;
                            en_nx    = 1'b1;
                            dl_nx    = clamp(jn_duty_l);
                            dr_nx    = clamp(jn_duty_r);
                            gnt_nx   = 1'b1;
                            cnt_nx   = jn_len;
                            done_nx  = (jn_len == CNT_W'(1));
                        end else begin
                            state_nx   = S_DEAD;
                            pend_jn_nx = 1'b1;
                            cnt_nx     = DT_LOAD;
                        end
                    end else if (lf_valid) begin
                        owner_nx = 2'd1;
                        if (lf_dir == mot_dir) begin
                            state_nx = S_FOLLOW;
                            en_nx    = 1'b1;
                            dl_nx    = clamp(lf_duty_l);
                            dr_nx    = clamp(lf_duty_r);
                        end else begin
                            state_nx   = S_DEAD;
                            pend_jn_nx = 1'b0;
                            cnt_nx     = DT_LOAD;
                        end
                    end
                end
                S_MANEUVER: begin
                    if (cnt <= CNT_W'(1)) begin
                        state_nx = S_IDLE;
                    end else begin
                        cnt_nx   = cnt - CNT_W'(1);
                        en_nx    = 1'b1;
                        dl_nx    = mot_duty_l;
                        dr_nx    = mot_duty_r;
                        owner_nx = 2'd2;
                        gnt_nx   = 1'b1;
                        done_nx  = (cnt == CNT_W'(2));
                    end
                end
                S_DEAD: begin
                    owner_nx = pend_jn ? 2'd2 : 2'd1;
                    if (cnt > CNT_W'(1)) begin
                        cnt_nx = cnt - CNT_W'(1);
                    end else if (pend_jn) begin
                        state_nx = S_MANEUVER;
                        en_nx    = 1'b1;
                        dir_nx   = jl_dir;
                        dl_nx    = clamp(jl_duty_l);
                        dr_nx    = clamp(jl_duty_r);
                        gnt_nx   = 1'b1;
                        cnt_nx   = jl_len;
                        done_nx  = (jl_len == CNT_W'(1));
                    end else if (lf_valid) begin
                        // direction is taken fresh: the bridge has already been idle long enough
                        state_nx = S_FOLLOW;
                        en_nx    = 1'b1;
                        dir_nx   = lf_dir;
                        dl_nx    = clamp(lf_duty_l);
                        dr_nx    = clamp(lf_duty_r);
                    end else begin
                        state_nx = S_IDLE;
                        owner_nx = 2'd0;
                    end
                end
                S_COLLIDE: state_nx = S_IDLE;
                default:   state_nx = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            pend_jn    <= 1'b0;
            cnt        <= '0;
            jl_dir     <= 2'b11;
            jl_duty_l  <= 7'd0;
            jl_duty_r  <= 7'd0;
            jl_cycles  <= '0;
            mot_en     <= 1'b0;
            mot_dir    <= 2'b11;
            mot_duty_l <= 7'd0;
            mot_duty_r <= 7'd0;
            owner      <= 2'd0;
            jn_gnt     <= 1'b0;
            jn_done    <= 1'b0;
            jn_abort   <= 1'b0;
        end else begin
            state      <= state_nx;
            pend_jn    <= pend_jn_nx;
            cnt        <= cnt_nx;
            jl_dir     <= jl_dir_nx;
            jl_duty_l  <= jl_duty_l_nx;
            jl_duty_r  <= jl_duty_r_nx;
            jl_cycles  <= jl_cycles_nx;
            mot_en     <= en_nx;
            mot_dir    <= dir_nx;
            mot_duty_l <= dl_nx;
            mot_duty_r <= dr_nx;
            owner      <= owner_nx;
            jn_gnt     <= gnt_nx;
            jn_done    <= done_nx;
            jn_abort   <= abort_nx;
        end
    end

endmodule

// File: tb/tb_drive_arbiter.sv
// Bench for drive_arbiter: directed scenarios with literal expectations, then random traffic
// compared every cycle against a behavioural model of the arbitration rules.
module tb_drive_arbiter;

    localparam int DT    = 4;
    localparam int CNT_W = 27;

    logic             clk, rst_n, col_stop, lf_valid, jn_req;
    logic [1:0]       lf_dir, jn_dir;
    logic [6:0]       lf_duty_l, lf_duty_r, jn_duty_l, jn_duty_r;
    logic [CNT_W-1:0] jn_cycles;
    logic             jn_gnt, jn_done, jn_abort, mot_en;
    logic [1:0]       mot_dir, owner;
    logic [6:0]       mot_duty_l, mot_duty_r;

    int errors = 0;
    int checks = 0;

    drive_arbiter #(.DEADTIME_CYCLES(DT), .MAX_DUTY(80), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .col_stop(col_stop), .lf_valid(lf_valid), .lf_dir(lf_dir),
        .lf_duty_l(lf_duty_l), .lf_duty_r(lf_duty_r), .jn_req(jn_req), .jn_dir(jn_dir),
        .jn_duty_l(jn_duty_l), .jn_duty_r(jn_duty_r), .jn_cycles(jn_cycles),
        .jn_gnt(jn_gnt), .jn_done(jn_done), .jn_abort(jn_abort), .mot_en(mot_en),
        .mot_dir(mot_dir), .mot_duty_l(mot_duty_l), .mot_duty_r(mot_duty_r), .owner(owner)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- behavioural model ----------------
    logic       e_en, e_gnt, e_done, e_abort;
    logic [1:0] e_dir, e_own;
    logic [6:0] e_dl, e_dr;
    int         dead_left, pend_who, man_left, lj_cyc;
    logic [1:0] lj_dir;
    logic [6:0] lj_l, lj_r;

    function automatic logic [6:0] cl(input logic [6:0] d);
        return (int'(d) > 80) ? 7'd80 : d;
    endfunction

    task automatic m_reset();
        e_en = 0; e_gnt = 0; e_done = 0; e_abort = 0; e_dir = 2'b11; e_own = 0;
        e_dl = 0; e_dr = 0; dead_left = 0; pend_who = 0; man_left = 0;
    endtask

    task automatic m_start(input logic [1:0] d, input logic [6:0] l, input logic [6:0] r, input int c);
        man_left = (c < 1) ? 1 : c;
        e_en = 1; e_dir = d; e_dl = cl(l); e_dr = cl(r); e_own = 2; e_gnt = 1;
        e_done = (man_left == 1);
    endtask

    task automatic m_step();
        bit in_dead, in_man, in_col;
        in_dead = (dead_left > 0);
        in_man  = !in_dead && e_gnt;
        in_col  = !in_dead && (e_own == 2'd3);
        e_en = 0; e_dl = 0; e_dr = 0; e_own = 0; e_gnt = 0; e_done = 0; e_abort = 0;
        if (col_stop) begin
            e_own = 3;
            e_abort = in_man || (in_dead && pend_who == 2);
            dead_left = 0; man_left = 0;
        end else if (in_col) begin
            e_own = 0;
        end else if (in_man) begin
            if (man_left > 1) begin
                man_left--;
                e_en = 1; e_dl = cl(lj_l); e_dr = cl(lj_r); e_own = 2; e_gnt = 1;
                e_done = (man_left == 1);
            end else man_left = 0;
        end else if (in_dead) begin
            if (dead_left > 1) begin
                dead_left--;
                e_own = 2'(pend_who);
            end else begin
                dead_left = 0;
                if (pend_who == 2) m_start(lj_dir, lj_l, lj_r, lj_cyc);
                else if (lf_valid) begin
                    e_en = 1; e_dir = lf_dir; e_dl = cl(lf_duty_l); e_dr = cl(lf_duty_r); e_own = 1;
                end
            end
        end else if (jn_req) begin
            lj_dir = jn_dir; lj_l = jn_duty_l; lj_r = jn_duty_r; lj_cyc = int'(jn_cycles);
            if (jn_dir == e_dir) m_start(jn_dir, jn_duty_l, jn_duty_r, int'(jn_cycles));
            else begin dead_left = DT; pend_who = 2; e_own = 2; end
        end else if (lf_valid) begin
            if (lf_dir == e_dir) begin
                e_en = 1; e_dl = cl(lf_duty_l); e_dr = cl(lf_duty_r); e_own = 1;
            end else begin dead_left = DT; pend_who = 1; e_own = 1; end
        end
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) m_reset();
            else m_step();
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        logic [21:0] act, exp;
        #1;
        forever begin
            @(negedge clk);
            act = {mot_en, mot_dir, mot_duty_l, mot_duty_r, owner, jn_gnt, jn_done, jn_abort};
            exp = {e_en, e_dir, e_dl, e_dr, e_own, e_gnt, e_done, e_abort};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL model_cycle t=%0t: got %h expected %h", $time, act, exp);
            end
        end
    end

    // ---------------- directed + random stimulus ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n, gcnt, dcnt, dat, bad;
        bit seen;
        rst_n = 0; col_stop = 0; lf_valid = 0; lf_dir = 2'b11; lf_duty_l = 0; lf_duty_r = 0;
        jn_req = 0; jn_dir = 2'b11; jn_duty_l = 0; jn_duty_r = 0; jn_cycles = '0;
        step(); step();
        chk("reset_state", 32'({mot_en, mot_dir, mot_duty_l, mot_duty_r, owner, jn_gnt, jn_done, jn_abort}),
            32'({1'b0, 2'b11, 7'd0, 7'd0, 2'd0, 3'b000}));
        rst_n = 1;
        step();

        // follower, same direction: drives one cycle later without dead-time
        lf_valid = 1; lf_dir = 2'b11; lf_duty_l = 27; lf_duty_r = 33;
        step();
        chk("follow_start", 32'({mot_en, mot_duty_l, mot_duty_r, owner}), 32'({1'b1, 7'd27, 7'd33, 2'd1}));
        lf_duty_l = 100;
        step();
        chk("follow_clamp", 32'(mot_duty_l), 32'd80);

        // direction flip: exactly DT idle cycles at the old direction
        lf_dir = 2'b01;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (mot_en) break;
            if (mot_dir == 2'b11) n++;
        end
        chk("dead_len", 32'(n), 32'd4);
        chk("dead_newdir", 32'({mot_en, mot_dir}), 32'({1'b1, 2'b01}));

        // maneuver preempting follower (needs a flip first); lf must not leak through
        jn_req = 1; jn_dir = 2'b11; jn_duty_l = 40; jn_duty_r = 42; jn_cycles = 10;
        gcnt = 0; dcnt = 0; dat = 0; bad = 0; seen = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            lf_duty_l = 7'($urandom_range(0, 127));
            lf_duty_r = 7'($urandom_range(0, 127));
            jn_duty_l = 7'($urandom_range(0, 127));
            if (jn_gnt) begin
                seen = 1; jn_req = 0; gcnt++;
                if (mot_duty_l != 7'd40 || mot_duty_r != 7'd42) bad++;
            end
            if (jn_done) begin dcnt++; dat = gcnt; end
            if (seen && !jn_gnt) break;
        end
        lf_valid = 0;
        chk("man_gnt_len", 32'(gcnt), 32'd10);
        chk("man_done_cnt", 32'(dcnt), 32'd1);
        chk("man_done_pos", 32'(dat), 32'd10);
        chk("man_duty_latched", 32'(bad), 32'd0);
        chk("man_exit_owner", 32'({owner, jn_gnt}), 32'd0);

        // collision at maneuver cycle 5
        jn_req = 1; jn_duty_l = 40; jn_duty_r = 42; jn_cycles = 10;
        for (int i = 0; i < 10; i++) begin
            step();
            if (jn_gnt) break;
        end
        jn_req = 0;
        repeat (4) step();
        chk("man_c5_gnt", 32'({jn_gnt, owner}), 32'({1'b1, 2'd2}));
        col_stop = 1;
        step();
        chk("col_abort", 32'({mot_en, owner, jn_gnt, jn_abort, jn_done}), 32'({1'b0, 2'd3, 1'b0, 1'b1, 1'b0}));
        col_stop = 0;
        step();
        chk("col_release", 32'({owner, jn_abort, jn_done, mot_en}), 32'd0);

        // simultaneous requests, zero-length maneuver
        jn_req = 1; jn_dir = 2'b11; jn_cycles = 0; lf_valid = 1; lf_dir = 2'b11;
        step();
        chk("zero_len_man", 32'({jn_gnt, jn_done, owner}), 32'({1'b1, 1'b1, 2'd2}));
        jn_req = 0;
        step();
        chk("zero_len_end", 32'({jn_gnt, jn_done}), 32'd0);

        // reset in the middle of a dead-time from a non-default direction
        lf_dir = 2'b10;
        for (int i = 0; i < 20; i++) begin
            step();
            if (mot_en) break;
        end
        lf_dir = 2'b01;
        step(); step();
        #2 rst_n = 0;
        #1;
        chk("reset_mid_dead", 32'({mot_en, mot_dir, mot_duty_l, mot_duty_r, owner, jn_gnt, jn_done, jn_abort}),
            32'({1'b0, 2'b11, 7'd0, 7'd0, 2'd0, 3'b000}));
        step();
        rst_n = 1;

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            step();
            if (jn_gnt || jn_abort) jn_req = 0;
            else if (!jn_req && $urandom_range(0, 99) < 6) jn_req = 1;
            jn_dir    = 2'($urandom_range(0, 3));
            jn_duty_l = 7'($urandom_range(0, 127));
            jn_duty_r = 7'($urandom_range(0, 127));
            jn_cycles = CNT_W'($urandom_range(0, 12));
            if (col_stop) col_stop = ($urandom_range(0, 1) == 1);
            else col_stop = ($urandom_range(0, 99) < 2);
            if ($urandom_range(0, 99) < 5) lf_valid = ~lf_valid;
            if ($urandom_range(0, 99) < 8) lf_dir = 2'($urandom_range(0, 3));
            lf_duty_l = 7'($urandom_range(0, 127));
            lf_duty_r = 7'($urandom_range(0, 127));
            if (i == 1500) begin
                #2 rst_n = 0;
                jn_req = 0; col_stop = 0;
                #3 rst_n = 1;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/drive_arbiter.md
Name: drive_arbiter

Overview:
- Owns the wheel command bus that feeds the PWM/H-bridge driver.
- Arbitrates between three requesters, highest priority first: collision stop, junction maneuver (timed, handshaked), line follower.
- Clamps duty to the H-bridge limit.
- Inserts a dead-time when either wheel reverses, so the bridge never flips direction under drive.

Parameters:
- DEADTIME_CYCLES, 50_000, cycles with drive disabled before a direction change takes effect (1 ms at 50 MHz).
- MAX_DUTY, 80, duty ceiling in percent; larger requests are clamped.
- CNT_W, 27, width of the maneuver and dead-time counters.

Ports:
- clk, in, 1, system clock (50 MHz).
- rst_n, in, 1, asynchronous active-low reset.
- col_stop, in, 1, collision present (active high).
- lf_valid, in, 1, line-follower command valid.
- lf_dir, in, 2, {left,right} wheel direction; 1 = forward.
- lf_duty_l, in, 7, left duty request, percent 0-127.
- lf_duty_r, in, 7, right duty request, percent 0-127.
- jn_req, in, 1, junction maneuver request; held high until jn_gnt.
- jn_dir, in, 2, maneuver wheel directions.
- jn_duty_l, in, 7, maneuver left duty.
- jn_duty_r, in, 7, maneuver right duty.
- jn_cycles, in, CNT_W, maneuver length in cycles.
- jn_gnt, out, 1, high for every cycle the maneuver drives the wheels.
- jn_done, out, 1, 1-cycle pulse when the maneuver completes normally.
- jn_abort, out, 1, 1-cycle pulse when collision kills a granted or pending maneuver.
- mot_en, out, 1, drive enable to the PWM block.
- mot_dir, out, 2, {left,right} direction to the H-bridge.
- mot_duty_l, out, 7, clamped left duty.
- mot_duty_r, out, 7, clamped right duty.
- owner, out, 2, current owner: 0 none, 1 line follower, 2 junction, 3 collision.

Behaviour:
- Reset and clocking
  - One clock domain; rst_n asynchronous, active low.
  - Reset values: state IDLE; mot_en=0, mot_duty_l=mot_duty_r=0, mot_dir=2'b11, owner=0, jn_gnt=jn_done=jn_abort=0; counters cleared.
  - Reset asserted mid-maneuver returns to these values immediately; no jn_done or jn_abort is issued.
- General output rules
  - All outputs are registered; a command accepted in cycle N appears at the outputs in cycle N+1.
  - Clamp: mot_duty = min(req, MAX_DUTY), applied per wheel.
  - Duty is 0 whenever mot_en=0.
- States: IDLE, FOLLOW, MANEUVER, DEAD, COLLIDE.
- COLLIDE
  - col_stop=1 in any state moves to COLLIDE on the next edge: mot_en=0, duties 0, mot_dir unchanged, owner=3.
  - If leaving MANEUVER, or leaving DEAD with a pending junction: jn_gnt drops and jn_abort pulses once.
  - col_stop=0 in COLLIDE -> IDLE next edge.
- IDLE
  - mot_en=0, owner=0.
  - Priority: jn_req beats lf_valid when both are high in the same cycle.
  - Request accepted with direction equal to mot_dir -> target state entered directly.
  - Request accepted with direction different from mot_dir -> DEAD, with the pending owner recorded.
- Junction acceptance (from IDLE or FOLLOW)
  - jn_dir, jn_duty_l/_r and jn_cycles are latched at acceptance.
  - Later changes on the jn_* inputs are ignored until the next acceptance.
- FOLLOW
  - Outputs track lf_* each cycle with 1-cycle latency; owner=1.
  - lf_valid=0 -> IDLE.
  - lf_dir != mot_dir -> DEAD, pending owner line follower.
  - jn_req=1 -> accepted as in IDLE; the maneuver preempts the follower.
- DEAD
  - mot_en=0, duties 0; mot_dir holds its old value; counter runs DEADTIME_CYCLES cycles.
  - On expiry: mot_dir takes the new direction and the pending owner's state is entered with mot_en=1.
  - Pending line follower uses the current lf_* values at expiry.
  - lf_valid=0 during a DEAD pending line follower -> IDLE on expiry.
  - A jn_req arriving during a DEAD pending line follower is served after expiry, from FOLLOW.
- MANEUVER
  - jn_gnt=1, owner=2; outputs come from the latched junction values.
  - Counter runs max(jn_cycles,1) cycles.
  - On the final cycle jn_done pulses; state -> IDLE next edge; jn_gnt deasserts with that transition.
  - lf_valid is ignored for the whole maneuver.
- jn_req is not re-sampled until the cycle after jn_done or jn_abort.

Test Plan (DEADTIME_CYCLES=4):
- Reset, then lf_valid=1, lf_dir=11, duties 27/33 -> one cycle later mot_en=1, mot_duty=27/33, owner=1; no DEAD entry.
- FOLLOW with lf_duty_l=100 -> mot_duty_l=80 (clamp).
- In FOLLOW, lf_dir 11->01 -> mot_en=0 for exactly 4 cycles with mot_dir=11, then mot_dir=01, mot_en=1.
- jn_req with jn_dir=11, duties 40/42, jn_cycles=10 -> jn_gnt high 10 cycles, jn_done single pulse on the 10th, then IDLE; lf ignored throughout.
- col_stop pulsed at maneuver cycle 5 -> next edge mot_en=0, owner=3, jn_gnt=0, jn_abort 1-cycle pulse, no jn_done; col_stop low -> IDLE.
- jn_req and lf_valid rise together; jn_cycles=0 -> junction wins, jn_gnt high 1 cycle with jn_done; rst_n pulled low mid-DEAD -> all outputs at reset values immediately.
